// File: rtl/matmul_stream.sv
// Streaming signed matrix multiplier: A (n x k) and B (k x q) loaded element-serially, C = A*B
// emitted row-major with one MAC per output. Optional column-major B load via MATMUL_STREAM_BCOL_EN.
module matmul_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIM    = 32,
  parameter int DIMW       = $clog2(MAX_DIM + 1),
  parameter int ACC_W      = 2 * DATA_WIDTH + $clog2(MAX_DIM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DIMW-1:0]              dim_n,
  input  logic [DIMW-1:0]              dim_k,
  input  logic [DIMW-1:0]              dim_k2,
  input  logic [DIMW-1:0]              dim_q,
`ifdef MATMUL_STREAM_BCOL_EN
  input  logic                         b_col_major,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_W-1:0]      out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int MEMD  = MAX_DIM * MAX_DIM;
  localparam int ADDRW = $clog2(MEMD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t                         state_q;
  logic [DIMW-1:0]                n_q, k_q, q_q;
  logic [DIMW-1:0]                r_q, c_q;
  logic [DIMW-1:0]                i_q, j_q, kk_q;
  logic                           bcol_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [ACC_W-1:0]        out_data_q;
  logic                           out_valid_q, out_last_q, in_ready_q;
  logic                           busy_q, done_q, err_q;

  logic signed [DATA_WIDTH-1:0]   a_mem [MEMD];
  logic signed [DATA_WIDTH-1:0]   b_mem [MEMD];

  logic                           dims_ok_s, bcol_start_s, in_fire_s;
  logic                           a_we_s, b_we_s, r_end_s, c_end_s, load_done_s, col_first_s;
  logic [DIMW-1:0]                row_lim_s, col_lim_s, r_d, c_d;
  logic [ADDRW-1:0]               wr_addr_s;
  logic signed [DATA_WIDTH-1:0]   a_rd_s, b_rd_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]        prod_ext_s, acc_d;

  function automatic logic [ADDRW-1:0] addr_f(input logic [DIMW-1:0] row, input logic [DIMW-1:0] col);
    return ADDRW'(int'(row) * MAX_DIM + int'(col));
  endfunction

`ifdef MATMUL_STREAM_BCOL_EN
  assign bcol_start_s = b_col_major;
`else
  assign bcol_start_s = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  assign in_fire_s = in_valid & in_ready_q;
  assign a_we_s    = in_fire_s && (state_q == S_LOAD_A);
  assign b_we_s    = in_fire_s && (state_q == S_LOAD_B);
  assign wr_addr_s = addr_f(r_q, c_q);

  assign dims_ok_s = (dim_n != '0) && (dim_n <= DIMW'(MAX_DIM)) &&
                     (dim_k != '0) && (dim_k <= DIMW'(MAX_DIM)) &&
                     (dim_q != '0) && (dim_q <= DIMW'(MAX_DIM)) &&
                     (dim_k == dim_k2);

  // Load-counter walk: A and row-major B advance column first, column-major B advances row first.
  always_comb begin
    row_lim_s   = (state_q == S_LOAD_A) ? n_q : k_q;
    col_lim_s   = (state_q == S_LOAD_A) ? k_q : q_q;
    r_end_s     = (r_q == row_lim_s - DIMW'(1));
    c_end_s     = (c_q == col_lim_s - DIMW'(1));
    load_done_s = r_end_s && c_end_s;
    col_first_s = (state_q == S_LOAD_B) && bcol_q;
    r_d = r_q;
    c_d = c_q;
    if (col_first_s) begin
      if (r_end_s) begin
        r_d = '0;
        c_d = c_q + DIMW'(1);
      end else begin
        r_d = r_q + DIMW'(1);
      end
    end else begin
      if (c_end_s) begin
        c_d = '0;
        r_d = r_q + DIMW'(1);
      end else begin
        c_d = c_q + DIMW'(1);
      end
    end
  end

  assign a_rd_s     = a_mem[addr_f(i_q, kk_q)];
  assign b_rd_s     = b_mem[addr_f(kk_q, j_q)];
  assign prod_s     = a_rd_s * b_rd_s;
  assign prod_ext_s = {{(ACC_W - 2 * DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
  assign acc_d      = (kk_q == '0) ? prod_ext_s : acc_q + prod_ext_s;

  // Operand buffers are deliberately left out of reset; every job rewrites what it reads.
  always_ff @(posedge clk) begin
    if (a_we_s) a_mem[wr_addr_s] <= in_data;
    if (b_we_s) b_mem[wr_addr_s] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      kk_q        <= '0;
      bcol_q      <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (dims_ok_s) begin
              n_q        <= dim_n;
              k_q        <= dim_k;
              q_q        <= dim_q;
              bcol_q     <= bcol_start_s;
              r_q        <= '0;
              c_q        <= '0;
              err_q      <= 1'b0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_LOAD_A;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_fire_s) begin
            r_q <= r_d;
            c_q <= c_d;
            if (load_done_s) begin
              r_q <= '0;
              c_q <= '0;
              if (state_q == S_LOAD_A) begin
                state_q <= S_LOAD_B;
              end else begin
                state_q    <= S_COMPUTE;
                in_ready_q <= 1'b0;
                i_q        <= '0;
                j_q        <= '0;
                kk_q       <= '0;
              end
            end
          end
        end
        S_COMPUTE: begin
          acc_q <= acc_d;
          if (kk_q == k_q - DIMW'(1)) begin
            kk_q        <= '0;
            out_data_q  <= acc_d;
            out_valid_q <= 1'b1;
            out_last_q  <= (i_q == n_q - DIMW'(1)) && (j_q == q_q - DIMW'(1));
            state_q     <= S_OUTPUT;
          end else begin
            kk_q <= kk_q + DIMW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            kk_q        <= '0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              if (j_q == q_q - DIMW'(1)) begin
                j_q <= '0;
                i_q <= i_q + DIMW'(1);
              end else begin
                j_q <= j_q + DIMW'(1);
              end
              state_q <= S_COMPUTE;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream.sv
// Directed bench for matmul_stream: vector table of small jobs plus hand sequences for
// errors, latency, backpressure, max size and asynchronous reset.
module tb_matmul_stream;
  localparam int DW    = 16;
  localparam int MD    = 32;
  localparam int DIMW  = 6;
  localparam int ACC_W = 37;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic [DIMW-1:0]         dim_n = '0, dim_k = '0, dim_k2 = '0, dim_q = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [DW-1:0]    in_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_last, busy, done, err;
`ifdef MATMUL_STREAM_BCOL_EN
  logic                    b_col_major = 1'b0;
`endif

  matmul_stream #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dim_n(dim_n), .dim_k(dim_k), .dim_k2(dim_k2), .dim_q(dim_q),
`ifdef MATMUL_STREAM_BCOL_EN
    .b_col_major(b_col_major),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n, k, q;
    int a[4];
    int b[4];
    int e[4];
  } vec_t;

  vec_t tbl[6];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start(input int n, input int k, input int k2, input int q, input bit bcol);
    dim_n = DIMW'(n); dim_k = DIMW'(k); dim_k2 = DIMW'(k2); dim_q = DIMW'(q);
`ifdef MATMUL_STREAM_BCOL_EN
    b_col_major = bcol;
`else
    if (bcol) $display("note: column-major B not built in");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int v);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = DW'(v);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic recv(input longint e, input bit e_last, input string nm);
    int t = 0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (!out_valid) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_data"}, out_data, e);
    chk({nm, "_last"}, longint'(out_last), longint'(e_last));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input bit bcol, input string nm);
    do_start(v.n, v.k, v.k, v.q, bcol);
    chk({nm, "_err_clear"}, longint'(err), 0);
    chk({nm, "_busy"}, longint'(busy), 1);
    for (int x = 0; x < v.n * v.k; x++) send(v.a[x]);
    if (bcol) begin
      for (int c = 0; c < v.q; c++)
        for (int r = 0; r < v.k; r++) send(v.b[r * v.q + c]);
    end else begin
      for (int x = 0; x < v.k * v.q; x++) send(v.b[x]);
    end
    for (int x = 0; x < v.n * v.q; x++) recv(v.e[x], x == v.n * v.q - 1, nm);
  endtask

  task automatic err_start(input int n, input int k, input int k2, input int q, input string nm);
    do_start(n, k, k2, q, 1'b0);
    chk({nm, "_err"}, longint'(err), 1);
    chk({nm, "_done"}, longint'(done), 1);
    chk({nm, "_busy"}, longint'(busy), 0);
    chk({nm, "_in_ready"}, longint'(in_ready), 0);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, longint'(done), 0);
    chk({nm, "_in_ready_idle"}, longint'(in_ready), 0);
  endtask

  initial begin
    int d0, lat, t;
    tbl[0] = '{2, 2, 2, '{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50}};
    tbl[1] = '{1, 2, 1, '{-3, 4, 0, 0}, '{5, -2, 0, 0}, '{-23, 0, 0, 0}};
    tbl[2] = '{1, 1, 1, '{-32768, 0, 0, 0}, '{-32768, 0, 0, 0}, '{1073741824, 0, 0, 0}};
    tbl[3] = '{2, 1, 2, '{2, -3, 0, 0}, '{4, -5, 0, 0}, '{8, -10, -12, 15}};
    tbl[4] = '{1, 2, 2, '{7, -1, 0, 0}, '{2, 3, 4, -6}, '{10, 27, 0, 0}};
    tbl[5] = '{1, 2, 1, '{32767, -32768, 0, 0}, '{-32768, -32768, 0, 0}, '{32768, 0, 0, 0}};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b1;
    @(negedge clk);

    // Stray operand traffic while idle must not land in the buffers.
    in_valid = 1'b1; in_data = 16'sd99;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;

    // Basic 2x2 job with latency and backpressure checks.
    d0 = done_cnt;
    do_start(2, 2, 2, 2, 1'b0);
    chk("basic_busy", longint'(busy), 1);
    chk("basic_in_ready", longint'(in_ready), 1);
    for (int x = 0; x < 4; x++) send(tbl[0].a[x]);
    for (int x = 0; x < 4; x++) send(tbl[0].b[x]);
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("first_latency", lat, 3);
    recv(19, 1'b0, "basic0");
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data", out_data, 22);
      @(negedge clk);
    end
    recv(22, 1'b0, "basic1");
    recv(43, 1'b0, "basic2");
    recv(50, 1'b1, "basic3");
    repeat (2) @(negedge clk);
    chk("basic_busy_end", longint'(busy), 0);
    chk("basic_done_count", done_cnt - d0, 1);

    err_start(3, 2, 3, 2, "err_k_mismatch");
    for (int v = 0; v < 6; v++) run_job(tbl[v], 1'b0, $sformatf("vec%0d", v));
    err_start(0, 2, 2, 2, "err_n0");
    run_job(tbl[1], 1'b0, "after_n0");
    err_start(33, 2, 2, 2, "err_n33");
    err_start(2, 2, 2, 0, "err_q0");

    // Largest job: all ones, irregular in_valid gaps.
    do_start(32, 32, 32, 32, 1'b0);
    for (int x = 0; x < 2 * MD * MD; x++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(1);
    end
    for (int x = 0; x < MD * MD; x++) recv(32, x == MD * MD - 1, "max");

    // Asynchronous reset in the middle of LOAD_B.
    do_start(2, 2, 2, 2, 1'b0);
    for (int x = 0; x < 6; x++) send(x + 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_in_ready", longint'(in_ready), 0);
    chk("arst_out_valid", longint'(out_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(tbl[0], 1'b0, "post_reset");
`ifdef MATMUL_STREAM_BCOL_EN
    run_job(tbl[0], 1'b1, "bcol");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
